// File: rtl/chain_pkg.sv
// Shared sizing helpers for the chain dual dot-product engine.
// Optional feature macro: CHAIN_PACKED_MULT_EN (one packed multiplier per lane).
package chain_pkg;

    // Set when each lane folds both weights into one multiplier.
`ifdef CHAIN_PACKED_MULT_EN
    localparam bit PACKED = 1'b1;
`else
    localparam bit PACKED = 1'b0;
`endif

    // Result width large enough for the largest magnitude dot product.
    function automatic int out_w_f(input int n, input int w, input int s);
        longint m;
        if (s != 0) begin
            m = (longint'(1) << (2 * w - 2)) * longint'(n);
        end else begin
            m = ((longint'(1) << w) - 1) * ((longint'(1) << w) - 1) * longint'(n);
        end
        return $clog2(m) + 1;
    endfunction

    // Number of registered adder levels.
    function automatic int tree_depth_f(input int n);
        return $clog2(n);
    endfunction

    // Lane count rounded up to a power of two; extra lanes feed zeros.
    function automatic int lane_pad_f(input int n);
        return 1 << $clog2(n);
    endfunction

    // Width of one lane product (a packed product carries both fields).
    function automatic int prod_w_f(input int w, input int ow, input bit pk);
        return pk ? (ow + 2 * w + 3) : (2 * w + 2);
    endfunction

    localparam int DEF_LANES = 1024;
    localparam int DEF_PAD   = lane_pad_f(DEF_LANES);

endpackage

// File: rtl/chain_lane_mult.sv
// One lane: operand register (stage 0) then registered product (stage 1).
// Ports: clk, rst_n, x_i/wj_i/wk_i operands; pj_o/pk_o products, or p_o
// packed product when CHAIN_PACKED_MULT_EN is defined.
module chain_lane_mult
    import chain_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIGN  = 1,
    parameter int OUT_W = 25,
    parameter int PW    = prod_w_f(WIDTH, OUT_W, PACKED)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        x_i,
    input  logic [WIDTH-1:0]        wj_i,
    input  logic [WIDTH-1:0]        wk_i,
`ifdef CHAIN_PACKED_MULT_EN
    output logic signed [PW-1:0]    p_o
`else
    output logic signed [PW-1:0]    pj_o,
    output logic signed [PW-1:0]    pk_o
`endif
);

    typedef logic signed [WIDTH:0] op_t;

    // One guard bit lets signed and unsigned operands share signed math.
    function automatic op_t ext(input logic [WIDTH-1:0] v);
        return {(SIGN != 0) && v[WIDTH-1], v};
    endfunction

    op_t x_q, wj_q, wk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q  <= '0;
            wj_q <= '0;
            wk_q <= '0;
        end else begin
            x_q  <= ext(x_i);
            wj_q <= ext(wj_i);
            wk_q <= ext(wk_i);
        end
    end

`ifdef CHAIN_PACKED_MULT_EN
    localparam int KW = OUT_W + WIDTH + 2;

    logic signed [KW-1:0] pack;
    logic signed [PW-1:0] p_d, p_q;

    // wj sits above an OUT_W-bit field holding wk.
    assign pack = KW'($signed({wj_q, {OUT_W{1'b0}}})) + KW'(wk_q);
    assign p_d  = PW'(pack) * PW'(x_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;
`else
    logic signed [PW-1:0] pj_d, pk_d, pj_q, pk_q;

    assign pj_d = PW'(x_q) * PW'(wj_q);
    assign pk_d = PW'(x_q) * PW'(wk_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pj_q <= '0;
            pk_q <= '0;
        end else begin
            pj_q <= pj_d;
            pk_q <= pk_d;
        end
    end

    assign pj_o = pj_q;
    assign pk_o = pk_q;
`endif

endmodule

// File: rtl/chain.sv
// Two pipelined dot products sharing activation x; latency 2+clog2(N).
// Ports: clk, rst_n, inputs/weights_j/weights_k vectors; out_j, out_k.
// Macro CHAIN_PACKED_MULT_EN: one packed multiplier and tree per lane.
module chain
    import chain_pkg::*;
#(
    parameter int  NUM_INPUTS = 1024,
    parameter int  WIDTH      = 8,
    parameter int  SIGN       = 1,
    localparam int OUT_W      = out_w_f(NUM_INPUTS, WIDTH, SIGN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        inputs    [NUM_INPUTS],
    input  logic [WIDTH-1:0]        weights_j [NUM_INPUTS],
    input  logic [WIDTH-1:0]        weights_k [NUM_INPUTS],
    output logic signed [OUT_W-1:0] out_j,
    output logic signed [OUT_W-1:0] out_k
);

    localparam int D  = tree_depth_f(NUM_INPUTS);
    localparam int NP = lane_pad_f(NUM_INPUTS);
    localparam int NT = PACKED ? 1 : 2;
    localparam int BW = prod_w_f(WIDTH, OUT_W, PACKED);
    localparam int TW = BW + D;

    logic signed [BW-1:0] lp   [NT][NUM_INPUTS];
    logic signed [TW-1:0] root [NT];
    logic                 unused_hi;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        chain_lane_mult #(
            .WIDTH (WIDTH),
            .SIGN  (SIGN),
            .OUT_W (OUT_W),
            .PW    (BW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .x_i   (inputs[i]),
            .wj_i  (weights_j[i]),
            .wk_i  (weights_k[i]),
`ifdef CHAIN_PACKED_MULT_EN
            .p_o   (lp[0][i])
`else
            .pj_o  (lp[0][i]),
            .pk_o  (lp[1][i])
`endif
        );
    end

    // Level l holds NP>>l partial sums, each one bit wider than below.
    for (genvar t = 0; t < NT; t++) begin : g_tree
        for (genvar l = 0; l <= D; l++) begin : g_lvl
            localparam int LW = BW + l;
            localparam int LN = NP >> l;
            logic signed [LW-1:0] s_q [LN];
            if (l == 0) begin : g_leaf
                for (genvar i = 0; i < NP; i++) begin : g_pad
                    if (i < NUM_INPUTS) begin : g_use
                        assign s_q[i] = lp[t][i];
                    end else begin : g_zero
                        assign s_q[i] = '0;
                    end
                end
            end else begin : g_add
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < LN; i++) begin
                            s_q[i] <= '0;
                        end
                    end else begin
                        for (int i = 0; i < LN; i++) begin
                            s_q[i] <= LW'(g_lvl[l-1].s_q[2*i])
                                    + LW'(g_lvl[l-1].s_q[2*i+1]);
                        end
                    end
                end
            end
        end
        assign root[t] = TW'(g_lvl[D].s_q[0]);
    end

`ifdef CHAIN_PACKED_MULT_EN
    // A negative low field borrowed one from the upper field; give it back.
    logic brw;
    assign brw       = (SIGN != 0) && root[0][OUT_W-1];
    assign out_k     = root[0][OUT_W-1:0];
    assign out_j     = root[0][2*OUT_W-1:OUT_W] + {{(OUT_W-1){1'b0}}, brw};
    assign unused_hi = ^root[0][TW-1:2*OUT_W];
`else
    assign out_j     = root[0][OUT_W-1:0];
    assign out_k     = root[1][OUT_W-1:0];
    assign unused_hi = ^{root[0][TW-1:OUT_W], root[1][TW-1:OUT_W]};
`endif

endmodule

// File: tb/tb_chain.sv
// Bench for chain: signed and unsigned instances against a delay-line
// model of exact dot products, plus directed corner scenarios.
module tb_chain;

    localparam int N   = 1024;
    localparam int W   = 8;
    localparam int L   = 12;
    localparam int OWS = 25;
    localparam int OWU = 27;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [W-1:0] xv  [N];
    logic [W-1:0] wjv [N];
    logic [W-1:0] wkv [N];

    logic signed [OWS-1:0] oj_s, ok_s;
    logic signed [OWU-1:0] oj_u, ok_u;

    int checks = 0;
    int errors = 0;

    longint hjs [L];
    longint hks [L];
    longint hju [L];
    longint hku [L];

    logic [W-1:0] ext_tab [4] = '{8'h80, 8'h7F, 8'hFF, 8'h00};

    always #5 clk = ~clk;

    chain #(.NUM_INPUTS(N), .WIDTH(W), .SIGN(1)) u_dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .inputs    (xv),
        .weights_j (wjv),
        .weights_k (wkv),
        .out_j     (oj_s),
        .out_k     (ok_s)
    );

    chain #(.NUM_INPUTS(N), .WIDTH(W), .SIGN(0)) u_dut_u (
        .clk       (clk),
        .rst_n     (rst_n),
        .inputs    (xv),
        .weights_j (wjv),
        .weights_k (wkv),
        .out_j     (oj_u),
        .out_k     (ok_u)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m -= (longint'(1) << w);
        return m;
    endfunction

    task automatic clear_hist();
        for (int s = 0; s < L; s++) begin
            hjs[s] = 0;
            hks[s] = 0;
            hju[s] = 0;
            hku[s] = 0;
        end
    endtask

    task automatic set_all(input int x, input int j, input int k);
        for (int i = 0; i < N; i++) begin
            xv[i]  = W'(x);
            wjv[i] = W'(j);
            wkv[i] = W'(k);
        end
    endtask

    task automatic rand_vec(input int mode);
        for (int i = 0; i < N; i++) begin
            if (mode == 0) begin
                xv[i]  = W'($urandom);
                wjv[i] = W'($urandom);
                wkv[i] = W'($urandom);
            end else if (mode == 1) begin
                if ($urandom_range(0, 15) == 0) begin
                    xv[i]  = W'($urandom);
                    wjv[i] = W'($urandom);
                    wkv[i] = W'($urandom);
                end else begin
                    xv[i]  = '0;
                    wjv[i] = '0;
                    wkv[i] = '0;
                end
            end else begin
                xv[i]  = ext_tab[$urandom_range(0, 3)];
                wjv[i] = ext_tab[$urandom_range(0, 3)];
                wkv[i] = ext_tab[$urandom_range(0, 3)];
            end
        end
    endtask

    // Called at a negedge: the current vectors are sampled at the next
    // posedge and should appear L edges later (counting that edge).
    task automatic step();
        longint sjs = 0;
        longint sks = 0;
        longint sju = 0;
        longint sku = 0;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                sjs += longint'($signed(xv[i])) * longint'($signed(wjv[i]));
                sks += longint'($signed(xv[i])) * longint'($signed(wkv[i]));
                sju += longint'(xv[i]) * longint'(wjv[i]);
                sku += longint'(xv[i]) * longint'(wkv[i]);
            end
        end
        @(posedge clk);
        for (int s = L - 1; s > 0; s--) begin
            hjs[s] = hjs[s-1];
            hks[s] = hks[s-1];
            hju[s] = hju[s-1];
            hku[s] = hku[s-1];
        end
        hjs[0] = wrap(sjs, OWS);
        hks[0] = wrap(sks, OWS);
        hju[0] = wrap(sju, OWU);
        hku[0] = wrap(sku, OWU);
        @(negedge clk);
        check("mdl_oj_s", oj_s, hjs[L-1]);
        check("mdl_ok_s", ok_s, hks[L-1]);
        check("mdl_oj_u", oj_u, hju[L-1]);
        check("mdl_ok_u", ok_u, hku[L-1]);
    endtask

    initial begin
        set_all(0, 0, 0);
        clear_hist();
        #1 rst_n = 1'b0;
        #1;
        check("rst_oj_s", oj_s, 0);
        check("rst_ok_s", ok_s, 0);
        check("rst_oj_u", oj_u, 0);
        check("rst_ok_u", ok_u, 0);
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;

        // Dense ones, one cycle only: exact latency of 12 edges.
        set_all(1, 1, -1);
        step();
        set_all(0, 0, 0);
        for (int s = 2; s <= L; s++) begin
            step();
            if (s == L - 1) check("dense_early", oj_s, 0);
        end
        check("dense_oj", oj_s, 1024);
        check("dense_ok", ok_s, -1024);

        // Single active lane.
        set_all(0, 0, 0);
        xv[5]  = 8'd23;
        wjv[5] = 8'd3;
        wkv[5] = 8'hFE;
        repeat (L) step();
        check("lane5_oj", oj_s, 69);
        check("lane5_ok", ok_s, -46);

        // Signed wrap boundary.
        set_all(-128, -128, 127);
        repeat (L) step();
        check("wrap_oj", oj_s, -16777216);
        check("wrap_ok", ok_s, -16646144);

        // Unsigned maximum.
        set_all(255, 255, 255);
        repeat (L) step();
        check("umax_oj", oj_u, 66585600);
        check("umax_ok", ok_u, 66585600);
        check("umax_sgn", oj_s, 1024);

        // Streaming: x=k at cycle k, result 1024*k twelve edges later.
        for (int j = 0; j < 42; j++) begin
            set_all((j < 30) ? j : 0, 1, 1);
            step();
            if (j >= L - 1 && j - (L - 1) < 30) begin
                check("stream", oj_s, 1024 * (j - (L - 1)));
            end
        end

        // Reset between edges while data is in flight.
        for (int j = 0; j < 4; j++) begin
            rand_vec(0);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_oj_s", oj_s, 0);
        check("mid_rst_ok_s", ok_s, 0);
        check("mid_rst_oj_u", oj_u, 0);
        check("mid_rst_ok_u", ok_u, 0);
        clear_hist();
        step();
        rst_n = 1'b1;
        set_all(1, 1, -1);
        for (int s = 1; s <= L; s++) begin
            step();
            if (s < L) check("rst_hold", oj_s, 0);
        end
        check("rst_after_oj", oj_s, 1024);
        check("rst_after_ok", ok_s, -1024);

        // Randomized traffic, mixing dense, sparse and extreme values.
        for (int j = 0; j < 60; j++) begin
            rand_vec($urandom_range(0, 2));
            step();
        end
        set_all(0, 0, 0);
        repeat (L) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chain.md
CHAIN -- requirements
Module: chain

Interface
REQ-001 Parameters, one per line:
- NUM_INPUTS, default 1024, number of dot-product lanes (1 or more).
- WIDTH, default 8, bits per input and per weight.
- SIGN, default 1; 1 means operands are two's-complement, 0 means unsigned.
REQ-002 Localparam OUT_W SHALL be defined as follows:
- SIGN=1: OUT_W = clog2((2^(WIDTH-1))^2 * NUM_INPUTS) + 1.
- SIGN=0: OUT_W = clog2((2^WIDTH-1)^2 * NUM_INPUTS) + 1.
- Defaults give 25 (signed) and 27 (unsigned).
REQ-003 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-004 Ports, one per line:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inputs  input  WIDTH x NUM_INPUTS unpacked array  activation vector x.
- weights_j  input  WIDTH x NUM_INPUTS unpacked array  first (top) weight vector.
- weights_k  input  WIDTH x NUM_INPUTS unpacked array  second (bottom) weight vector.
- out_j  output  OUT_W, declared signed  registered sum of x[i]*weights_j[i].
- out_k  output  OUT_W, declared signed  registered sum of x[i]*weights_k[i].

Function
REQ-005 Every cycle the block SHALL sample all three vectors and compute two dot products that share the activation vector x.
REQ-006 Operand extension SHALL follow SIGN: sign-extend when SIGN=1, zero-extend when SIGN=0, regardless of how the ports are declared.
REQ-007 Pipeline stages:
- Stage 0 registers the operands.
- Stage 1 registers the per-lane products.
- The adder tree adds one register per level, clog2(NUM_INPUTS) levels.
- Lanes SHALL be zero-padded to the next power of two.
REQ-008 Latency L = 2 + clog2(NUM_INPUTS): 12 for 1024 lanes, 2 for 1 lane. Throughput SHALL be one result pair per cycle with no stalls.
REQ-009 Each tree level SHALL be one bit wider than the level below it. The final result SHALL be truncated to OUT_W bits, wrapping modulo 2^OUT_W with no saturation.
REQ-010 out_j and out_k SHALL be bit-exact equal to the mathematical sums, modulo 2^OUT_W.
REQ-011 No handshake: the inputs presented at edge n SHALL produce the outputs visible after edge n+L.

Reset
REQ-012 While rst_n is 0, all pipeline registers, out_j and out_k SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-013 After rst_n is released, out_j and out_k SHALL read 0 until the first sampled vector emerges, which is L cycles after the first post-release edge.
REQ-014 Asserting reset mid-operation SHALL discard all in-flight data. No partial sums SHALL survive.

Configuration
REQ-015 With macro CHAIN_PACKED_MULT_EN defined, each lane SHALL use one shared multiplier:
- Product P = (wj * 2^OUT_W + wk) * x.
- Packed P values SHALL be summed through the tree.
- out_k = low OUT_W bits of the sum, interpreted signed.
- out_j = upper field of the sum plus the sign-bit borrow of the low field (borrow added only when SIGN=1).
REQ-016 Without CHAIN_PACKED_MULT_EN, each lane SHALL use two independent multipliers and two separate trees.
REQ-017 Outputs and latency SHALL be identical with and without CHAIN_PACKED_MULT_EN.

Structure
REQ-018 A shared package chain_pkg SHALL hold:
- the OUT_W computation function;
- the tree-depth function;
- the lane-padding constant.
REQ-019 One sub-module chain_lane_mult SHALL implement the per-lane registered product in both the packed and unpacked variants. The adder tree SHALL be generate-loops inside chain.

Verification
REQ-020 Directed scenarios the bench SHALL cover (defaults unless stated):
- Dense ones: x=1, wj=1, wk=-1 in all lanes -> out_j=1024, out_k=-1024 exactly 12 cycles after sampling.
- Single lane: lane 5 x=23, wj=3, wk=-2, all other lanes 0 -> out_j=69, out_k=-46.
- Wrap boundary: x=-128, wj=-128, wk=127 in all lanes -> out_j=-16777216 (2^24 wraps in 25 bits), out_k=-16646144.
- Unsigned max (SIGN=0): x=w=255 in all lanes -> out_j=out_k=66585600 in 27 bits.
- Reset mid-stream: pull rst_n low between edges -> outputs 0 immediately; after release, outputs 0 for 11 edges, then the correct value.
- Streaming: change x every cycle (x=k in all lanes at cycle k, wj=wk=1) -> out at cycle k+12 equals 1024*k, for both macro settings.
